// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: format codes (aligned with the core's ImmSel),
// constant encodings and the immediate range helper.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    FMT_R = 3'b101
  } fmt_e;

  localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // True when v is representable as a two's-complement value of the given width,
  // i.e. every bit from bits-1 upward is a copy of the sign.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] t;
    t = $signed(v) >>> (bits - 1);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_encoder.sv
// Combinational field packing for one instruction plus immediate range/alignment checks.
module imm_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = INSTR_ZERO;
    err   = 1'b0;
    case (fmt_e'(fmt))
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !fits_signed(imm, 12);
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !fits_signed(imm, 12);
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !fits_signed(imm, 13) || imm[0];
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !fits_signed(imm, 21) || imm[0];
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'h000);
      end
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      // Unknown formats emit an all-zero word and flag it.
      default: begin
        instr = INSTR_ZERO;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs fields via imm_encoder, buffers {instr,err} in a
// 2-entry in-order FIFO with valid/ready on both sides, and counts output handshakes.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] enc_count
);

  logic [31:0] enc_instr_p0;
  logic        enc_err_p0;
  logic [31:0] ent_instr_p1 [2];
  logic        ent_err_p1   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;
  logic        vld_p1;
  logic        push;
  logic        pop;

  // Stage p0: combinational encode of the presented fields
  imm_encoder u_imm_encoder (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .instr  (enc_instr_p0),
    .err    (enc_err_p0)
  );

  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready = (occ != 2'd2);
  assign vld_p1   = (occ != 2'd0);
  assign push     = in_valid && in_ready && !reset;
  assign pop      = vld_p1 && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ       <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      enc_count <= 16'h0000;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        enc_count <= enc_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Stage p1: FIFO storage; data is not reset, outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      ent_instr_p1[wr_ptr] <= enc_instr_p0;
      ent_err_p1[wr_ptr]   <= enc_err_p0;
    end
  end

  assign out_valid = vld_p1;
  assign instr     = vld_p1 ? ent_instr_p1[rd_ptr] : INSTR_ZERO;
  assign err       = vld_p1 ? ent_err_p1[rd_ptr]   : 1'b0;

endmodule
